// File: rtl/wir_decoded_if.sv
// Wrapper serial port bundle between the WIR and the wrapper control logic.
// Latency: n/a (wires only).
// Backpressure: none; the master drives enables and the WIR responds every WRCK edge.
interface wir_decoded_if #(
    parameter int WIR_LEN = 4
);
    logic               wir_si;
    logic               wir_shift;
    logic               wir_capture;
    logic               wir_update;
    logic               wir_so;
    logic [WIR_LEN-1:0] wir_instr;
    logic [11:0]        wir_dec;
    logic               wir_illegal;
    logic               wir_len_err;

    // Serial-port controller side: drives the scan enables and data.
    modport master (
        output wir_si, wir_shift, wir_capture, wir_update,
        input  wir_so, wir_instr, wir_dec, wir_illegal, wir_len_err
    );

    // WIR side: consumes the scan enables, presents the decoded instruction.
    modport slave (
        input  wir_si, wir_shift, wir_capture, wir_update,
        output wir_so, wir_instr, wir_dec, wir_illegal, wir_len_err
    );
endinterface

// File: rtl/wir_decoded.sv
// Encoded IEEE 1500 WIR with shift-length check and one-hot instruction decode.
// Latency: wir_so one edge after shift/capture; decode is combinational from the update register.
// Backpressure: none; updates after a wrong-length scan are dropped and flagged in wir_len_err.
module wir_decoded #(
    parameter int                 WIR_LEN     = 4,
    parameter logic [WIR_LEN-1:0] CAPTURE_VAL = WIR_LEN'(1)
) (
    input  logic         WRCK,
    input  logic         WRSTN,
    wir_decoded_if.slave bus
);

    // Counter must hold WIR_LEN+1 so any over-shift stays distinguishable from a good scan.
    localparam int               CNT_W    = $clog2(WIR_LEN + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIR_LEN);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIR_LEN + 1);

    generate
        if (WIR_LEN < 4) begin : g_len_check
            $error("wir_decoded: WIR_LEN must be at least 4");
        end
    endgenerate

    logic [WIR_LEN-1:0] sr_q,  sr_d;
    logic [WIR_LEN-1:0] upd_q, upd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [11:0]        dec;
    logic               illegal;

    // Next state: update samples pre-edge sr/cnt; capture/shift then override sr and cnt.
    always_comb begin
        sr_d  = sr_q;
        upd_d = upd_q;
        cnt_d = cnt_q;
        err_d = err_q;

        if (bus.wir_update) begin
            if (cnt_q == CNT_FULL) begin
                upd_d = sr_q;
                err_d = 1'b0;
            end else begin
                err_d = 1'b1;
            end
            cnt_d = '0;
        end

        if (bus.wir_capture) begin
            sr_d  = CAPTURE_VAL;
            cnt_d = '0;
        end else if (bus.wir_shift) begin
            sr_d  = {bus.wir_si, sr_q[WIR_LEN-1:1]};
            cnt_d = (cnt_q == CNT_SAT) ? CNT_SAT : cnt_q + CNT_W'(1);
        end
    end

    // State registers; synchronous reset wins over every enable.
    always_ff @(posedge WRCK) begin
        if (!WRSTN) begin
            sr_q  <= '0;
            upd_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            upd_q <= upd_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Opcodes 12 and above fall back to bypass so the decode is never all-zero.
    always_comb begin
        dec     = 12'h001;
        illegal = 1'b0;
        if (upd_q < WIR_LEN'(12)) begin
            dec = 12'h001 << upd_q;
        end else begin
            illegal = 1'b1;
        end
    end

    assign bus.wir_so      = sr_q[0];
    assign bus.wir_instr   = upd_q;
    assign bus.wir_dec     = dec;
    assign bus.wir_illegal = illegal;
    assign bus.wir_len_err = err_q;

endmodule

// File: tb/tb_wir_decoded.sv
// Directed bench for wir_decoded: per-edge vector table for WIR_LEN=4 plus hand sequences.
// Latency: outputs checked 1 ns after each rising WRCK edge.
// Backpressure: n/a.
module tb_wir_decoded;

    logic WRCK = 1'b0;
    logic rstn4, rstn6;
    int   checks = 0;
    int   errors = 0;

    always #5 WRCK = ~WRCK;

    wir_decoded_if #(.WIR_LEN(4)) bus4 ();
    wir_decoded_if #(.WIR_LEN(6)) bus6 ();

    wir_decoded #(.WIR_LEN(4), .CAPTURE_VAL(4'b0001)) dut4 (
        .WRCK(WRCK), .WRSTN(rstn4), .bus(bus4.slave)
    );
    wir_decoded #(.WIR_LEN(6), .CAPTURE_VAL(6'b000001)) dut6 (
        .WRCK(WRCK), .WRSTN(rstn6), .bus(bus6.slave)
    );

    typedef struct {
        logic        rstn, cap, sh, up, si;
        logic        so;
        logic [3:0]  instr;
        logic [11:0] dec;
        logic        ill, err;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rstn, cap, sh, up, si,
                       input logic so, input logic [3:0] instr, input logic [11:0] dec,
                       input logic ill, err, input string name);
        vec_t v;
        v.rstn = rstn; v.cap = cap; v.sh = sh; v.up = up; v.si = si;
        v.so = so; v.instr = instr; v.dec = dec; v.ill = ill; v.err = err; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step4(input logic rstn, cap, sh, up, si);
        rstn4 = rstn;
        bus4.wir_capture = cap; bus4.wir_shift = sh; bus4.wir_update = up; bus4.wir_si = si;
        @(posedge WRCK);
        #1;
    endtask

    task automatic chk4(input string name, input logic so, input logic [3:0] instr,
                        input logic [11:0] dec, input logic ill, err);
        chk({name, ".so"},    32'(bus4.wir_so),      32'(so));
        chk({name, ".instr"}, 32'(bus4.wir_instr),   32'(instr));
        chk({name, ".dec"},   32'(bus4.wir_dec),     32'(dec));
        chk({name, ".ill"},   32'(bus4.wir_illegal), 32'(ill));
        chk({name, ".err"},   32'(bus4.wir_len_err), 32'(err));
    endtask

    task automatic step6(input logic cap, sh, up, si);
        bus6.wir_capture = cap; bus6.wir_shift = sh; bus6.wir_update = up; bus6.wir_si = si;
        @(posedge WRCK);
        #1;
    endtask

    initial begin
        // rstn cap sh up si | so instr dec ill err
        add(0,1,1,1,1, 0,4'd0, 12'h001,0,0, "rst0");
        add(0,1,1,1,1, 0,4'd0, 12'h001,0,0, "rst1");
        // Good load of 5 (LSB first 1,0,1,0)
        add(1,1,0,0,0, 1,4'd0, 12'h001,0,0, "g5_cap");
        add(1,0,1,0,1, 0,4'd0, 12'h001,0,0, "g5_sh1");
        add(1,0,1,0,0, 0,4'd0, 12'h001,0,0, "g5_sh2");
        add(1,0,1,0,1, 0,4'd0, 12'h001,0,0, "g5_sh3");
        add(1,0,1,0,0, 1,4'd0, 12'h001,0,0, "g5_sh4");
        add(1,0,0,1,0, 1,4'd5, 12'h020,0,0, "g5_upd");
        // Short scan: 3 shifts
        add(1,1,0,0,0, 1,4'd5, 12'h020,0,0, "sh_cap");
        add(1,0,1,0,0, 0,4'd5, 12'h020,0,0, "sh_s1");
        add(1,0,1,0,0, 0,4'd5, 12'h020,0,0, "sh_s2");
        add(1,0,1,0,0, 0,4'd5, 12'h020,0,0, "sh_s3");
        add(1,0,0,1,0, 0,4'd5, 12'h020,0,1, "sh_upd");
        // Long scan: 7 shifts of 1
        add(1,1,0,0,0, 1,4'd5, 12'h020,0,1, "ln_cap");
        add(1,0,1,0,1, 0,4'd5, 12'h020,0,1, "ln_s1");
        add(1,0,1,0,1, 0,4'd5, 12'h020,0,1, "ln_s2");
        add(1,0,1,0,1, 0,4'd5, 12'h020,0,1, "ln_s3");
        add(1,0,1,0,1, 1,4'd5, 12'h020,0,1, "ln_s4");
        add(1,0,1,0,1, 1,4'd5, 12'h020,0,1, "ln_s5");
        add(1,0,1,0,1, 1,4'd5, 12'h020,0,1, "ln_s6");
        add(1,0,1,0,1, 1,4'd5, 12'h020,0,1, "ln_s7");
        add(1,0,0,1,0, 1,4'd5, 12'h020,0,1, "ln_upd");
        // Correct load of 4 (LSB first 0,0,1,0) clears the error
        add(1,1,0,0,0, 1,4'd5, 12'h020,0,1, "g4_cap");
        add(1,0,1,0,0, 0,4'd5, 12'h020,0,1, "g4_sh1");
        add(1,0,1,0,0, 0,4'd5, 12'h020,0,1, "g4_sh2");
        add(1,0,1,0,1, 0,4'd5, 12'h020,0,1, "g4_sh3");
        add(1,0,1,0,0, 0,4'd5, 12'h020,0,1, "g4_sh4");
        add(1,0,0,1,0, 0,4'd4, 12'h010,0,0, "g4_upd");
        // Illegal opcode 13 (LSB first 1,0,1,1)
        add(1,1,0,0,0, 1,4'd4, 12'h010,0,0, "il_cap");
        add(1,0,1,0,1, 0,4'd4, 12'h010,0,0, "il_sh1");
        add(1,0,1,0,0, 0,4'd4, 12'h010,0,0, "il_sh2");
        add(1,0,1,0,1, 0,4'd4, 12'h010,0,0, "il_sh3");
        add(1,0,1,0,1, 1,4'd4, 12'h010,0,0, "il_sh4");
        add(1,0,0,1,0, 1,4'd13,12'h001,1,0, "il_upd");
        // Idle holds everything
        add(1,0,0,0,1, 1,4'd13,12'h001,1,0, "idle");

        rstn6 = 1'b0;
        step6(1, 1, 1, 1);
        rstn6 = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step4(vecs[i].rstn, vecs[i].cap, vecs[i].sh, vecs[i].up, vecs[i].si);
            chk4(vecs[i].name, vecs[i].so, vecs[i].instr, vecs[i].dec, vecs[i].ill, vecs[i].err);
        end

        // Capture+shift together: capture wins, cnt restarts so a 4-shift load of 3 succeeds.
        step4(1, 1, 1, 0, 0);
        chk("cs_so", 32'(bus4.wir_so), 32'd1);
        step4(1, 0, 1, 0, 1);
        step4(1, 0, 1, 0, 1);
        step4(1, 0, 1, 0, 0);
        step4(1, 0, 1, 0, 0);
        chk("cs_sh4_so", 32'(bus4.wir_so), 32'd1);
        step4(1, 0, 0, 1, 0);
        chk4("cs_upd", 1'b1, 4'd3, 12'h008, 1'b0, 1'b0);

        // Update on the 4th shift edge sees cnt=3 and is rejected; the shift still counts.
        step4(1, 1, 0, 0, 0);
        step4(1, 0, 1, 0, 0);
        step4(1, 0, 1, 0, 0);
        step4(1, 0, 1, 0, 0);
        step4(1, 0, 1, 1, 0);
        chk4("su_upd", 1'b0, 4'd3, 12'h008, 1'b0, 1'b1);
        step4(1, 0, 0, 1, 0);
        chk4("su_after", 1'b0, 4'd0, 12'h001, 1'b0, 1'b0);

        // Mid-scan reset with instr=5 and err set.
        step4(1, 1, 0, 0, 0);
        step4(1, 0, 1, 0, 1);
        step4(1, 0, 1, 0, 0);
        step4(1, 0, 1, 0, 1);
        step4(1, 0, 1, 0, 0);
        step4(1, 0, 0, 1, 0);
        step4(1, 1, 0, 0, 0);
        step4(1, 0, 1, 0, 0);
        step4(1, 0, 0, 1, 0);
        chk4("mr_pre", 1'b0, 4'd5, 12'h020, 1'b0, 1'b1);
        step4(1, 1, 0, 0, 0);
        step4(1, 0, 1, 0, 1);
        step4(1, 0, 1, 0, 1);
        step4(0, 0, 1, 1, 1);
        chk4("mr_rst", 1'b0, 4'd0, 12'h001, 1'b0, 1'b0);

        // WIR_LEN=6: load 11 (LSB first 1,1,0,1,0,0), then a 5-shift scan is rejected.
        chk("w6_rst_dec", 32'(bus6.wir_dec), 32'h001);
        step6(1, 0, 0, 0);
        chk("w6_cap_so", 32'(bus6.wir_so), 32'd1);
        step6(0, 1, 0, 1);
        step6(0, 1, 0, 1);
        step6(0, 1, 0, 0);
        step6(0, 1, 0, 1);
        step6(0, 1, 0, 0);
        step6(0, 1, 0, 0);
        chk("w6_sh6_so", 32'(bus6.wir_so), 32'd1);
        step6(0, 0, 1, 0);
        chk("w6_instr", 32'(bus6.wir_instr), 32'd11);
        chk("w6_dec", 32'(bus6.wir_dec), 32'h800);
        chk("w6_ill", 32'(bus6.wir_illegal), 32'd0);
        chk("w6_err", 32'(bus6.wir_len_err), 32'd0);
        step6(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step6(0, 1, 0, 0);
        step6(0, 0, 1, 0);
        chk("w6_short_instr", 32'(bus6.wir_instr), 32'd11);
        chk("w6_short_err", 32'(bus6.wir_len_err), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
